// File: rtl/rc4_sched.sv
// Sequences the RC4 init, KSA and PRGA sub-blocks and arbitrates their access
// to the shared S-memory port. A per-phase watchdog flags sub-blocks that never complete.
module rc4_sched #(
  parameter int PHASE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       err,
  output logic [1:0] phase,
  output logic       en_init,
  output logic       en_ksa,
  output logic       en_prga,
  input  logic       rdy_init,
  input  logic       rdy_ksa,
  input  logic       rdy_prga,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  localparam int CW = ($clog2(PHASE_TIMEOUT + 1) > 11) ? $clog2(PHASE_TIMEOUT + 1) : 11;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, START_INIT, WAIT_INIT_LO, WAIT_INIT_HI,
    START_KSA, WAIT_KSA_LO, WAIT_KSA_HI,
    START_PRGA, WAIT_PRGA_LO, WAIT_PRGA_HI,
    DONE, ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            timeout;
  logic            rdy_q, rdy_d, err_q, err_d;
  logic [1:0]      phase_q, phase_d;
  logic            en_init_q, en_init_d, en_ksa_q, en_ksa_d, en_prga_q, en_prga_d;

  // Timeout fires on the edge where the counter would reach PHASE_TIMEOUT-1,
  // so ERR is entered exactly PHASE_TIMEOUT cycles after the START pulse.
  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    timeout = (cnt_inc == CNT_LAST);
    case (state_q)
      IDLE, DONE: if (en) state_d = START_INIT;
      START_INIT: begin cnt_d = '0; state_d = WAIT_INIT_LO; end
      START_KSA:  begin cnt_d = '0; state_d = WAIT_KSA_LO;  end
      START_PRGA: begin cnt_d = '0; state_d = WAIT_PRGA_LO; end
      WAIT_INIT_LO: begin
        cnt_d = cnt_inc;
        if (!rdy_init)    state_d = WAIT_INIT_HI;
        else if (timeout) state_d = ERR;
      end
      WAIT_INIT_HI: begin
        cnt_d = cnt_inc;
        if (rdy_init)     state_d = START_KSA;
        else if (timeout) state_d = ERR;
      end
      WAIT_KSA_LO: begin
        cnt_d = cnt_inc;
        if (!rdy_ksa)     state_d = WAIT_KSA_HI;
        else if (timeout) state_d = ERR;
      end
      WAIT_KSA_HI: begin
        cnt_d = cnt_inc;
        if (rdy_ksa)      state_d = START_PRGA;
        else if (timeout) state_d = ERR;
      end
      WAIT_PRGA_LO: begin
        cnt_d = cnt_inc;
        if (!rdy_prga)    state_d = WAIT_PRGA_HI;
        else if (timeout) state_d = ERR;
      end
      WAIT_PRGA_HI: begin
        cnt_d = cnt_inc;
        if (rdy_prga)     state_d = DONE;
        else if (timeout) state_d = ERR;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    rdy_d     = (state_d == IDLE) || (state_d == DONE);
    err_d     = (state_d == ERR);
    en_init_d = (state_d == START_INIT);
    en_ksa_d  = (state_d == START_KSA);
    en_prga_d = (state_d == START_PRGA);
    case (state_d)
      START_INIT, WAIT_INIT_LO, WAIT_INIT_HI: phase_d = 2'd1;
      START_KSA,  WAIT_KSA_LO,  WAIT_KSA_HI:  phase_d = 2'd2;
      START_PRGA, WAIT_PRGA_LO, WAIT_PRGA_HI: phase_d = 2'd3;
      default:                                phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
      err_q     <= 1'b0;
      phase_q   <= 2'd0;
      en_init_q <= 1'b0;
      en_ksa_q  <= 1'b0;
      en_prga_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      en_init_q <= en_init_d;
      en_ksa_q  <= en_ksa_d;
      en_prga_q <= en_prga_d;
    end
  end

  assign rdy     = rdy_q;
  assign err     = err_q;
  assign phase   = phase_q;
  assign en_init = en_init_q;
  assign en_ksa  = en_ksa_q;
  assign en_prga = en_prga_q;

  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (phase_q)
      2'd1: begin s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren; end
      2'd2: begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;  end
      2'd3: begin s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_sched.sv
// Directed bench for rc4_sched: one default-timeout instance and one with
// PHASE_TIMEOUT=16 share all inputs; sub-block rdy behaviour is modelled per step.
module tb_rc4_sched;
  logic clk = 1'b0;
  logic rst, en;
  logic rdy_init, rdy_ksa, rdy_prga;
  logic [7:0] init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata;
  logic init_wren, ksa_wren, prga_wren;

  logic rdy, err, en_init, en_ksa, en_prga, s_wren;
  logic [1:0] phase;
  logic [7:0] s_addr, s_wrdata;
  logic rdy_t, err_t, en_init_t, en_ksa_t, en_prga_t, s_wren_t;
  logic [1:0] phase_t;
  logic [7:0] s_addr_t, s_wrdata_t;

  int checks = 0, fails = 0, cyc = 0;
  int bi, bk, bp, ci, ck, cp;
  int n_ei, n_ek, n_ep, c_ei, c_ek, c_ep, c_done, n_ph;
  logic [1:0] ph_ei, ph_ek, ph_ep, last_ph;

  always #5 clk = ~clk;

  rc4_sched dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .err(err), .phase(phase),
    .en_init(en_init), .en_ksa(en_ksa), .en_prga(en_prga),
    .rdy_init(rdy_init), .rdy_ksa(rdy_ksa), .rdy_prga(rdy_prga),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren));

  rc4_sched #(.PHASE_TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy_t), .err(err_t), .phase(phase_t),
    .en_init(en_init_t), .en_ksa(en_ksa_t), .en_prga(en_prga_t),
    .rdy_init(rdy_init), .rdy_ksa(rdy_ksa), .rdy_prga(rdy_prga),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr_t), .s_wrdata(s_wrdata_t), .s_wren(s_wren_t));

  // One clock; afterwards update the sub-block models from the default instance.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (en_init) begin n_ei++; c_ei = cyc; ph_ei = phase; ci = bi; end else if (ci > 0) ci--;
    if (en_ksa)  begin n_ek++; c_ek = cyc; ph_ek = phase; ck = bk; end else if (ck > 0) ck--;
    if (en_prga) begin n_ep++; c_ep = cyc; ph_ep = phase; cp = bp; end else if (cp > 0) cp--;
    rdy_init = (ci == 0);
    rdy_ksa  = (ck == 0);
    rdy_prga = (cp == 0);
    if (phase !== last_ph) begin n_ph++; last_ph = phase; end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    ci = 0; ck = 0; cp = 0;
    rdy_init = 1'b1; rdy_ksa = 1'b1; rdy_prga = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Starts a sequence; extra > 0 adds a second en pulse that many steps in.
  task automatic run_seq(input int extra);
    n_ei = 0; n_ek = 0; n_ep = 0; n_ph = 0; last_ph = phase;
    c_ei = 0; c_ek = 0; c_ep = 0; c_done = 0;
    for (int i = 0; i < 4000; i++) begin
      en = (i == 0 || i == extra);
      step();
      if (i > 0 && rdy) begin c_done = cyc; break; end
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    init_addr = 8'h00; ksa_addr = 8'h00; prga_addr = 8'h00;
    init_wrdata = 8'h00; ksa_wrdata = 8'h00; prga_wrdata = 8'h00;
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
    bi = 0; bk = 0; bp = 0;
    do_reset();
    en = 1'b0;
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got %0b expected 1", rdy); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b expected 0", err); end
    checks++; if (phase !== 2'd0) begin fails++; $display("FAIL reset_phase got %0d expected 0", phase); end
    checks++; if ({en_init, en_ksa, en_prga} !== 3'b000) begin fails++; $display("FAIL reset_en got %b expected 000", {en_init, en_ksa, en_prga}); end
    checks++; if ({s_wren, s_addr, s_wrdata} !== 17'h0) begin fails++; $display("FAIL reset_port got %h expected 0", {s_wren, s_addr, s_wrdata}); end
    step();
    checks++; if (en_init !== 1'b0 || rdy !== 1'b1) begin fails++; $display("FAIL reset_en_discard got en_init=%0b rdy=%0b expected 0/1", en_init, rdy); end
  endtask

  task automatic test_nominal();
    do_reset();
    bi = 256; bk = 768; bp = 50;
    run_seq(-1);
    checks++; if (c_done == 0) begin fails++; $display("FAIL nom_done_timeout got no DONE expected DONE"); end
    checks++; if ({n_ei, n_ek, n_ep} !== {32'd1, 32'd1, 32'd1}) begin fails++; $display("FAIL nom_pulses got %0d/%0d/%0d expected 1/1/1", n_ei, n_ek, n_ep); end
    checks++; if (c_ek - c_ei !== 257) begin fails++; $display("FAIL nom_ksa_start got %0d expected 257", c_ek - c_ei); end
    checks++; if (c_ep - c_ek !== 769) begin fails++; $display("FAIL nom_prga_start got %0d expected 769", c_ep - c_ek); end
    checks++; if (c_done - c_ep !== 51) begin fails++; $display("FAIL nom_done got %0d expected 51", c_done - c_ep); end
    checks++; if ({ph_ei, ph_ek, ph_ep} !== 6'b01_10_11) begin fails++; $display("FAIL nom_phase got %b expected 011011", {ph_ei, ph_ek, ph_ep}); end
    checks++; if (n_ph !== 4 || phase !== 2'd0) begin fails++; $display("FAIL nom_phase_seq got %0d changes phase=%0d expected 4/0", n_ph, phase); end
    checks++; if (rdy !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL nom_final got rdy=%0b err=%0b expected 1/0", rdy, err); end
  endtask

  task automatic test_arbitration();
    do_reset();
    bi = 10; bk = 10; bp = 10;
    en = 1'b1; step(); en = 1'b0;
    init_wren = 1'b1; init_addr = 8'h05; init_wrdata = 8'h3C;
    ksa_wren = 1'b1; ksa_addr = 8'h77; ksa_wrdata = 8'h99;
    prga_wren = 1'b1; prga_addr = 8'hAA; prga_wrdata = 8'hBB;
    #1;
    checks++; if ({s_wren, s_addr, s_wrdata} !== {1'b1, 8'h05, 8'h3C}) begin fails++; $display("FAIL arb_init got %h expected 1053c", {s_wren, s_addr, s_wrdata}); end
    for (int i = 0; i < 50 && phase != 2'd2; i++) step();
    step(); step();
    ksa_wren = 1'b0; ksa_addr = 8'h11; ksa_wrdata = 8'h5A;
    #1;
    checks++; if (phase !== 2'd2) begin fails++; $display("FAIL arb_in_ksa got phase=%0d expected 2", phase); end
    checks++; if ({s_wren, s_addr, s_wrdata} !== {1'b0, 8'h11, 8'h5A}) begin fails++; $display("FAIL arb_ksa got %h expected 0115a", {s_wren, s_addr, s_wrdata}); end
    ksa_wren = 1'b1;
    #1;
    checks++; if (s_wren !== 1'b1) begin fails++; $display("FAIL arb_ksa_wren got %0b expected 1", s_wren); end
    for (int i = 0; i < 50 && phase != 2'd3; i++) step();
    checks++; if ({s_wren, s_addr, s_wrdata} !== {1'b1, 8'hAA, 8'hBB}) begin fails++; $display("FAIL arb_prga got %h expected 1aabb", {s_wren, s_addr, s_wrdata}); end
    do_reset();
    checks++; if ({s_wren, s_addr, s_wrdata} !== 17'h0) begin fails++; $display("FAIL arb_idle_port got %h expected 0", {s_wren, s_addr, s_wrdata}); end
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bi = 10; bk = 40; bp = 10;
    en = 1'b1; step(); en = 1'b0;
    for (int i = 0; i < 50 && phase != 2'd2; i++) step();
    for (int i = 0; i < 5; i++) step();
    checks++; if (phase !== 2'd2) begin fails++; $display("FAIL mid_in_ksa got phase=%0d expected 2", phase); end
    rst = 1'b1; en = 1'b1; step(); rst = 1'b0; en = 1'b0;
    checks++; if ({rdy, err, phase, en_init, en_ksa, en_prga} !== 7'b10_00_000) begin fails++; $display("FAIL mid_after_rst got %b expected 1000000", {rdy, err, phase, en_init, en_ksa, en_prga}); end
    step();
    checks++; if (en_init !== 1'b0 || rdy !== 1'b1) begin fails++; $display("FAIL mid_en_discard got en_init=%0b rdy=%0b expected 0/1", en_init, rdy); end
    en = 1'b1; step(); en = 1'b0;
    checks++; if (en_init !== 1'b1 || phase !== 2'd1) begin fails++; $display("FAIL mid_restart got en_init=%0b phase=%0d expected 1/1", en_init, phase); end
  endtask

  task automatic test_back_to_back();
    int k1, p1, d1;
    do_reset();
    bi = 20; bk = 30; bp = 10;
    run_seq(5);
    k1 = c_ek - c_ei; p1 = c_ep - c_ek; d1 = c_done - c_ep;
    checks++; if (n_ei !== 1) begin fails++; $display("FAIL b2b_ignore_en got %0d en_init pulses expected 1", n_ei); end
    checks++; if (k1 !== 21 || p1 !== 31 || d1 !== 11) begin fails++; $display("FAIL b2b_first got %0d/%0d/%0d expected 21/31/11", k1, p1, d1); end
    run_seq(-1);
    checks++; if ({n_ei, n_ek, n_ep} !== {32'd1, 32'd1, 32'd1}) begin fails++; $display("FAIL b2b_second_pulses got %0d/%0d/%0d expected 1/1/1", n_ei, n_ek, n_ep); end
    checks++; if (c_ek - c_ei !== 21 || c_ep - c_ek !== 31 || c_done - c_ep !== 11) begin fails++; $display("FAIL b2b_second got %0d/%0d/%0d expected 21/31/11", c_ek - c_ei, c_ep - c_ek, c_done - c_ep); end
    checks++; if (rdy !== 1'b1 || err !== 1'b0 || n_ph !== 4) begin fails++; $display("FAIL b2b_final got rdy=%0b err=%0b nph=%0d expected 1/0/4", rdy, err, n_ph); end
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    bi = 3; bk = 1000000; bp = 0;
    n_ek = 0; seen = 0;
    en = 1'b1; step(); en = 1'b0;
    for (int i = 0; i < 100 && !err_t; i++) step();
    checks++; if (err_t !== 1'b1 || n_ek !== 1) begin fails++; $display("FAIL tmo_err got err=%0b n_ksa=%0d expected 1/1", err_t, n_ek); end
    checks++; if (cyc - c_ek !== 16) begin fails++; $display("FAIL tmo_latency got %0d expected 16", cyc - c_ek); end
    checks++; if (phase_t !== 2'd0 || rdy_t !== 1'b0) begin fails++; $display("FAIL tmo_outputs got phase=%0d rdy=%0b expected 0/0", phase_t, rdy_t); end
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; step(); en = 1'b0; step();
      if (en_init_t || !err_t || rdy_t) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL tmo_sticky got %0d bad cycles expected 0", seen); end
    do_reset();
    checks++; if (err_t !== 1'b0 || rdy_t !== 1'b1) begin fails++; $display("FAIL tmo_rst_clear got err=%0b rdy=%0b expected 0/1", err_t, rdy_t); end
  endtask

  task automatic test_zero_busy();
    int c0, bad;
    do_reset();
    bi = 0; bk = 0; bp = 0; bad = 0;
    en = 1'b1; step(); en = 1'b0;
    c0 = cyc;
    checks++; if (en_init_t !== 1'b1 || phase_t !== 2'd1) begin fails++; $display("FAIL zb_start got en_init=%0b phase=%0d expected 1/1", en_init_t, phase_t); end
    for (int i = 0; i < 100 && !err_t; i++) begin
      step();
      if (!err_t && (phase_t != 2'd1 || en_ksa_t)) bad++;
    end
    checks++; if (err_t !== 1'b1 || cyc - c0 !== 16) begin fails++; $display("FAIL zb_timeout got err=%0b after %0d expected 1 after 16", err_t, cyc - c0); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL zb_stuck got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    test_zero_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
